// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the NxN systolic array
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // Per-PE control seen on each clock: MAC enable, overwrite-vs-add, operand signedness
    typedef struct packed {
        logic valid;
        logic first;
        logic signed_op;
    } pe_ctrl_t;

    // Cycles from last-beat acceptance until the far-corner PE has taken its final product
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_nxn_if.sv
// rtl/systolic_nxn_if.sv - input beat and result row handshake bundle
interface systolic_nxn_if #(
    parameter int N           = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ACCUM_WIDTH = 64
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic                     in_last_i;
    logic [N*DATA_WIDTH-1:0]  a_vec_i;
    logic [N*DATA_WIDTH-1:0]  b_vec_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [N*ACCUM_WIDTH-1:0] out_row_o;
    logic [$clog2(N)-1:0]     out_row_idx_o;
    logic                     out_last_o;

    modport master (
        output in_valid_i, in_last_i, a_vec_i, b_vec_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_row_o, out_row_idx_o, out_last_o
    );

    modport slave (
        input  in_valid_i, in_last_i, a_vec_i, b_vec_i, out_ready_i,
        output in_ready_o, out_valid_o, out_row_o, out_row_idx_o, out_last_o
    );
endinterface

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one output-stationary MAC cell with A/B forwarding
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ACCUM_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   arm,
    input  logic                   signed_mode,
    input  logic [DATA_WIDTH-1:0]  a_west,
    input  logic                   a_west_valid,
    input  logic [DATA_WIDTH-1:0]  b_north,
    input  logic                   b_north_valid,
    output logic [DATA_WIDTH-1:0]  a_east,
    output logic                   a_east_valid,
    output logic [DATA_WIDTH-1:0]  b_south,
    output logic                   b_south_valid,
    output logic [ACCUM_WIDTH-1:0] acc
);
    // One guard bit per operand lets a single signed multiply serve both modes
    localparam int PW = 2 * DATA_WIDTH + 2;

    pe_ctrl_t              ctrl;
    logic                  fresh_q;
    logic signed [PW-1:0]  a_ext;
    logic signed [PW-1:0]  b_ext;
    logic signed [PW-1:0]  prod_full;
    logic [ACCUM_WIDTH-1:0] prod_acc;

    assign ctrl.valid     = a_west_valid & b_north_valid;
    assign ctrl.first     = fresh_q;
    assign ctrl.signed_op = signed_mode;

    assign a_ext     = PW'($signed({ctrl.signed_op & a_west[DATA_WIDTH-1], a_west}));
    assign b_ext     = PW'($signed({ctrl.signed_op & b_north[DATA_WIDTH-1], b_north}));
    assign prod_full = a_ext * b_ext;
    // Unsigned products are non-negative here, so sign extension doubles as zero extension
    assign prod_acc  = ACCUM_WIDTH'(prod_full);

    // Forward operands one hop and update the accumulator on every valid product
    always_ff @(posedge clk) begin
        if (rst) begin
            a_east        <= '0;
            a_east_valid  <= 1'b0;
            b_south       <= '0;
            b_south_valid <= 1'b0;
            acc           <= '0;
            fresh_q       <= 1'b0;
        end else begin
            a_east        <= a_west;
            a_east_valid  <= a_west_valid;
            b_south       <= b_north;
            b_south_valid <= b_north_valid;
            if (clear) begin
                acc <= '0;
            end else if (ctrl.valid) begin
                acc <= ctrl.first ? prod_acc : acc + prod_acc;
            end
            if (arm) begin
                fresh_q <= 1'b1;
            end else if (ctrl.valid) begin
                fresh_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/systolic_nxn.sv
// rtl/systolic_nxn.sv - NxN output-stationary systolic matrix multiplier
module systolic_nxn
    import systolic_pkg::*;
#(
    parameter int N           = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ACCUM_WIDTH = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            accumulate_i,
    input  logic            signed_i,
    input  logic            clear_i,
    output logic            busy_o,
    systolic_nxn_if.slave   io
);
    localparam int DL = drain_len(N);
    localparam int CW = $clog2(DL + 1) + 1;
    localparam int IW = $clog2(N);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   row_q, row_d;
    logic            sgn_q, sgn_d;
    logic            beat;
    logic            clear_acc;
    logic            arm;

    logic [DATA_WIDTH-1:0]  a_m  [N][N+1];
    logic                   av_m [N][N+1];
    logic [DATA_WIDTH-1:0]  b_m  [N+1][N];
    logic                   bv_m [N+1][N];
    logic [ACCUM_WIDTH-1:0] acc_w [N][N];

    assign beat      = io.in_valid_i & (state_q == FEED);
    assign clear_acc = (state_q == IDLE) & clear_i;
    assign arm       = (state_q == IDLE) & start_i & ~accumulate_i;

    // FSM state, drain counter, output row pointer and latched signedness
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            sgn_q   <= sgn_d;
        end
    end

    // Next-state logic: feed until the last beat, drain the skew, then hand out rows
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        sgn_d   = sgn_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sgn_d   = signed_i;
                    state_d = FEED;
                end
            end
            FEED: begin
                if (beat && io.in_last_i) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(DL)) begin
                    row_d   = '0;
                    state_d = OUTPUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUTPUT: begin
                if (io.out_ready_i) begin
                    if (row_q == IW'(N - 1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o           = (state_q != IDLE);
    assign io.in_ready_o    = (state_q == FEED);
    assign io.out_valid_o   = (state_q == OUTPUT);
    assign io.out_last_o    = (state_q == OUTPUT) && (row_q == IW'(N - 1));
    assign io.out_row_idx_o = row_q;

    // Present the selected accumulator row only while a result is on offer
    always_comb begin
        io.out_row_o = '0;
        if (state_q == OUTPUT) begin
            for (int c = 0; c < N; c++) begin
                io.out_row_o[c*ACCUM_WIDTH +: ACCUM_WIDTH] = acc_w[row_q][c];
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_askew
        if (r == 0) begin : g_direct
            assign a_m[0][0]  = io.a_vec_i[0 +: DATA_WIDTH];
            assign av_m[0][0] = beat;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] sr [r];
            logic                  vr [r];
            // Row r of A waits r cycles so it meets column c of B at PE(r,c) on time
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int j = 0; j < r; j++) begin
                        sr[j] <= '0;
                        vr[j] <= 1'b0;
                    end
                end else begin
                    sr[0] <= io.a_vec_i[r*DATA_WIDTH +: DATA_WIDTH];
                    vr[0] <= beat;
                    for (int j = 1; j < r; j++) begin
                        sr[j] <= sr[j-1];
                        vr[j] <= vr[j-1];
                    end
                end
            end
            assign a_m[r][0]  = sr[r-1];
            assign av_m[r][0] = vr[r-1];
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_bskew
        if (c == 0) begin : g_direct
            assign b_m[0][0]  = io.b_vec_i[0 +: DATA_WIDTH];
            assign bv_m[0][0] = beat;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] sr [c];
            logic                  vr [c];
            // Column c of B waits c cycles, mirroring the A-side skew
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int j = 0; j < c; j++) begin
                        sr[j] <= '0;
                        vr[j] <= 1'b0;
                    end
                end else begin
                    sr[0] <= io.b_vec_i[c*DATA_WIDTH +: DATA_WIDTH];
                    vr[0] <= beat;
                    for (int j = 1; j < c; j++) begin
                        sr[j] <= sr[j-1];
                        vr[j] <= vr[j-1];
                    end
                end
            end
            assign b_m[0][c]  = sr[c-1];
            assign bv_m[0][c] = vr[c-1];
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            systolic_pe #(
                .DATA_WIDTH  (DATA_WIDTH),
                .ACCUM_WIDTH (ACCUM_WIDTH)
            ) u_pe (
                .clk           (clk_i),
                .rst           (rst_i),
                .clear         (clear_acc),
                .arm           (arm),
                .signed_mode   (sgn_q),
                .a_west        (a_m[r][c]),
                .a_west_valid  (av_m[r][c]),
                .b_north       (b_m[r][c]),
                .b_north_valid (bv_m[r][c]),
                .a_east        (a_m[r][c+1]),
                .a_east_valid  (av_m[r][c+1]),
                .b_south       (b_m[r+1][c]),
                .b_south_valid (bv_m[r+1][c]),
                .acc           (acc_w[r][c])
            );
        end
    end

endmodule
